// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for serial_adder.
package serial_adder_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} sa_state_t;
   localparam int SA_WIDTH_DEFAULT = 8;
endpackage

// File: rtl/fa.sv
// fa: one-bit full adder.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder around one fa, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the out_ovf signed-overflow output.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             out_ovf,
`endif
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   sa_state_t        state;
   logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
   logic [CW-1:0]    cnt;
   logic             c, s, co;
`ifdef SERIAL_ADDER_OVF_EN
   logic             c_msb;
   assign out_ovf = c_msb ^ c;
`endif
   fa u_fa (.a(a_sr[0]), .b(b_sr[0]), .cin(c), .s(s), .cout(co));
   assign in_ready  = state == IDLE;
   assign busy      = state == RUN;
   assign out_valid = state == DONE;
   assign out_sum   = sum_sr;
   assign out_cout  = c;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         cnt    <= '0;
         c      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         c_msb  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_sr  <= in_a;
               b_sr  <= in_b;
               c     <= in_cin;
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               // shift-and-or form keeps WIDTH=1 free of an empty slice
               sum_sr <= (sum_sr >> 1) | (WIDTH'(s) << (WIDTH - 1));
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               c      <= co;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
`ifdef SERIAL_ADDER_OVF_EN
                  c_msb <= c;
`endif
               end
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
